// File: rtl/regfile_mp.sv
// Multi-ported register file with write forwarding and a busy
// scoreboard.
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   WE/WADR/WDATA   NWR write ports, packed per port
//   RADR/RDATA      NRD read ports, combinational, with write forwarding
//   RBUSY           per read port: the register has a pending writer
//   ISSUE_EN/ADR    mark a destination register pending
//   FLUSH           clear all pending marks
//   BUSY_CNT        number of pending registers
module regfile_mp #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NWR-1:0]       WE,
  input  logic [NWR*AW-1:0]    WADR,
  input  logic [NWR*WIDTH-1:0] WDATA,
  input  logic [NRD*AW-1:0]    RADR,
  output logic [NRD*WIDTH-1:0] RDATA,
  output logic [NRD-1:0]       RBUSY,
  input  logic                 ISSUE_EN,
  input  logic [AW-1:0]        ISSUE_ADR,
  input  logic                 FLUSH,
  output logic [AW:0]          BUSY_CNT
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Later ports overwrite earlier ones, so the highest index wins.
  // A write clears busy first; a same-cycle issue then re-sets it.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (WE[j] && WADR[j*AW +: AW] != '0) begin
        mem_d[WADR[j*AW +: AW]]  = WDATA[j*WIDTH +: WIDTH];
        busy_d[WADR[j*AW +: AW]] = 1'b0;
      end
    end
    if (FLUSH) begin
      busy_d = '0;
    end else if (ISSUE_EN && ISSUE_ADR != '0) begin
      busy_d[ISSUE_ADR] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q  <= '{default: '0};
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] fwd;
    logic             hit;

    assign ra = RADR[k*AW +: AW];

    always_comb begin
      hit = 1'b0;
      fwd = '0;
      for (int j = 0; j < NWR; j++) begin
        if (WE[j] && WADR[j*AW +: AW] == ra) begin
          hit = 1'b1;
          fwd = WDATA[j*WIDTH +: WIDTH];
        end
      end
    end

    // Register 0 is never written, so mem_q[0] stays 0.
    assign RDATA[k*WIDTH +: WIDTH] =
      (hit && rst && ra != '0) ? fwd : mem_q[ra];
    assign RBUSY[k] = busy_q[ra] & ~hit;
  end

  always_comb begin
    BUSY_CNT = '0;
    for (int i = 0; i < DEPTH; i++) begin
      BUSY_CNT = BUSY_CNT + {{AW{1'b0}}, busy_q[i]};
    end
  end

endmodule
